instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Upstream stage of the CU. Holds a small loadable program of 19-bit instructions, sequences a program counter, and issues opcode/operand_a/operand_b to the CU over a valid/ready handshake. Execution stops on a HALT opcode or at the end of program memory.

Parameters:
DEPTH, 16, number of instruction words in program memory (power of two, >=2)
ADDR_W, $clog2(DEPTH), program counter / load address width
INSTR_W, 19, instruction width: [18:16] opcode, [15:8] operand_a, [7:0] operand_b

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  synchronous active-low reset
load_en  in  1  program-memory write strobe
load_addr  in  ADDR_W  write address
load_data  in  INSTR_W  instruction word to write
start  in  1  begin execution from address 0
opcode_o  out  3  opcode to CU
operand_a_o  out  8  first operand to CU
operand_b_o  out  8  second operand to CU
valid_o  out  1  opcode/operand outputs hold an instruction
ready_i  in  1  CU accepts the current instruction
pc_o  out  ADDR_W  address of the instruction currently fetched or issued
busy_o  out  1  high in FETCH and ISSUE
done_o  out  1  high in HALT

Behaviour:
- Reset: one clk edge with rst_n=0 -> state IDLE; pc_o=0; valid_o, busy_o, done_o=0; opcode_o/operand_a_o/operand_b_o=0. Memory contents are not reset and survive reset.
- Reset mid-operation: abort immediately. Any pending valid_o drops the next cycle, with no handshake completion.
- Opcode 3'b000 = HALT and is never issued. Opcodes 001..111 = ADD, SUB, AND, OR, NOT, INC, DEC.
- Memory: synchronous write, synchronous read with 1-cycle latency.
- Writes are accepted only in IDLE or HALT. load_en in FETCH or ISSUE is ignored.
- IDLE: start=1 and load_en=0 -> FETCH, pc=0. If start and load_en are high together, the load executes and start is ignored.
- FETCH (1 cycle): read mem[pc].
  - If the opcode is HALT -> HALT; valid_o stays 0.
  - Otherwise -> ISSUE; outputs are loaded and valid_o=1 in the first ISSUE cycle.
- ISSUE:
  - Outputs and valid_o are held stable until valid_o&&ready_i.
  - On handshake with pc==DEPTH-1 -> HALT (wrap behaviour: see Optional Feature).
  - On handshake otherwise -> pc+1, FETCH; valid_o=0 the next cycle.
  - Peak throughput is one instruction per 2 cycles.
  - ready_i while valid_o=0 is ignored.
- HALT: done_o=1, busy_o=0. pc_o holds the last address. Outputs hold their last values with valid_o=0. start -> FETCH, pc=0, done_o=0.
- start during FETCH or ISSUE is ignored.
- pc arithmetic is unsigned ADDR_W and wraps modulo DEPTH.

Optional Feature:
Macro: FETCH_LOOP_EN
- Defined: a handshake at pc==DEPTH-1 wraps pc to 0 and continues in FETCH. Only a HALT opcode (or reset) stops execution.
- Undefined: a handshake at pc==DEPTH-1 enters HALT.

Decomposition:
- Package cpu_pkg:
  - OPCODE_W=3, DATA_W=8, INSTR_W=19.
  - Opcode enum: OP_HALT=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_NOT=5, OP_INC=6, OP_DEC=7.
  - FSM state typedef: IDLE, FETCH, ISSUE, HALT.
  - Field-slice constants for opcode and operands.
- Sub-module instr_mem (DEPTH x INSTR_W, sync write, sync read). The FSM and pc remain in instr_fetch_unit.

Test Plan:
- Reset then idle -> all outputs 0, busy_o=0, done_o=0. Start with memory preloaded -> busy_o=1 one cycle after start.
- Load addr0=19'b001_00100011_00010100, addr1=19'b010_00100011_00010100, addr2=0; start; ready_i=1 -> issues (1,0x23,0x14) at pc 0 and (2,0x23,0x14) at pc 1, 2 cycles apart. Then done_o=1 with pc_o=2.
- Same program with ready_i=0 for 5 cycles -> valid_o and opcode/operands remain stable at (1,0x23,0x14) and pc_o=0 throughout; ready_i=1 -> advances.
- Load all DEPTH words with opcode 7 (DEC), start, ready_i=1 -> 16 issues.
  - Without FETCH_LOOP_EN: HALT after pc 15.
  - With FETCH_LOOP_EN: pc_o returns to 0 and issuing continues.
- rst_n=0 asserted while in ISSUE -> next cycle IDLE, valid_o=0, pc_o=0. Restart without reloading -> the original program executes unchanged.
- load_en during ISSUE (addr1 <- HALT) -> ignored; addr1 still issues its original instruction. load_en and start together in IDLE -> word written, state stays IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch unit: opcodes, FSM states, field slices.
package cpu_pkg;

    localparam int OPCODE_W = 3;
    localparam int DATA_W   = 8;
    localparam int INSTR_W  = 19;

    localparam int OPC_LSB = 16;
    localparam int OPA_LSB = 8;
    localparam int OPB_LSB = 0;

    typedef enum logic [OPCODE_W-1:0] {
        OP_HALT = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_NOT  = 3'd5,
        OP_INC  = 3'd6,
        OP_DEC  = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_mem.sv
// Program memory: DEPTH x INSTR_W, synchronous write, synchronous read (1-cycle latency), not reset.
module instr_mem #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int INSTR_W = 19
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/issue sequencer feeding the CU over valid/ready. Build option FETCH_LOOP_EN: wrap pc to 0
// after the last word instead of halting.
//
// state | meaning
// IDLE  | waiting for start; program loads accepted
// FETCH | memory word for pc is on the read port; decide HALT vs ISSUE
// ISSUE | instruction held on outputs with valid_o until ready_i
// HALT  | program ended; done_o high, loads accepted, start reruns from 0
module instr_fetch_unit #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int INSTR_W = 19
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_en,
    input  logic [ADDR_W-1:0]             load_addr,
    input  logic [INSTR_W-1:0]            load_data,
    input  logic                          start,
    output logic [cpu_pkg::OPCODE_W-1:0]  opcode_o,
    output logic [cpu_pkg::DATA_W-1:0]    operand_a_o,
    output logic [cpu_pkg::DATA_W-1:0]    operand_b_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [ADDR_W-1:0]             pc_o,
    output logic                          busy_o,
    output logic                          done_o
);
    import cpu_pkg::*;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;
    logic [DATA_W-1:0]     opa_q, opa_d;
    logic [DATA_W-1:0]     opb_q, opb_d;
    logic [INSTR_W-1:0]    rd_data;
    logic                  mem_we;

    assign mem_we = load_en && ((state_q == IDLE) || (state_q == HALT));

    // Read address follows pc_d so the word for pc is already on the read port during FETCH.
    instr_mem #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_d),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            opcode_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        case (state_q)
            IDLE: begin
                if (start && !load_en) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                if (rd_data[OPC_LSB +: OPCODE_W] == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    state_d  = ISSUE;
                    opcode_d = rd_data[OPC_LSB +: OPCODE_W];
                    opa_d    = rd_data[OPA_LSB +: DATA_W];
                    opb_d    = rd_data[OPB_LSB +: DATA_W];
                end
            end
            ISSUE: begin
                if (ready_i) begin
`ifdef FETCH_LOOP_EN
                    state_d = FETCH;
                    pc_d    = pc_q + ADDR_W'(1);
`else
                    if (pc_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = HALT;
                    end else begin
                        state_d = FETCH;
                        pc_d    = pc_q + ADDR_W'(1);
                    end
`endif
                end
            end
            HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign opcode_o    = opcode_q;
    assign operand_a_o = opa_q;
    assign operand_b_o = opb_q;
    assign valid_o     = (state_q == ISSUE);
    assign pc_o        = pc_q;
    assign busy_o      = (state_q == FETCH) || (state_q == ISSUE);
    assign done_o      = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected issues queued at start, compared on each handshake.
module tb_instr_fetch_unit;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [18:0]       load_data;
    logic              start;
    logic [2:0]        opcode_o;
    logic [7:0]        operand_a_o;
    logic [7:0]        operand_b_o;
    logic              valid_o;
    logic              ready_i;
    logic [ADDR_W-1:0] pc_o;
    logic              busy_o;
    logic              done_o;

    instr_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(19)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .opcode_o    (opcode_o),
        .operand_a_o (operand_a_o),
        .operand_b_o (operand_b_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .pc_o        (pc_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]        op;
        logic [7:0]        a;
        logic [7:0]        b;
        logic [ADDR_W-1:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   prev_hs;
    bit   have_prev = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Handshake monitor: one pop per accepted instruction, plus issue spacing at full rate.
    always @(negedge clk) begin
        if (!busy_o) have_prev = 0;
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                chk("issue_op", 32'(opcode_o), 32'(e.op));
                chk("issue_a", 32'(operand_a_o), 32'(e.a));
                chk("issue_b", 32'(operand_b_o), 32'(e.b));
                chk("issue_pc", 32'(pc_o), 32'(e.pc));
            end
            if (have_prev) chk("issue_gap", 32'(cyc - prev_hs), 2);
            prev_hs   = cyc;
            have_prev = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [18:0] data);
        load_en   = 1'b1;
        load_addr = ADDR_W'(addr);
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int pc);
        exp_t x;
        x.op = op; x.a = a; x.b = b; x.pc = ADDR_W'(pc);
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_o && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(done_o), 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid_o && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(valid_o), 1);
    endtask

    task automatic push_base();
        push(3'd1, 8'h23, 8'h14, 0);
        push(3'd2, 8'h23, 8'h14, 1);
    endtask

    initial begin
        rst_n = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; ready_i = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_pc", 32'(pc_o), 0);
        chk("rst_outs", {13'd0, opcode_o, operand_a_o, operand_b_o}, 0);

        // Basic two-instruction program at full rate
        tick();
        load_word(0, 19'b001_00100011_00010100);
        load_word(1, 19'b010_00100011_00010100);
        load_word(2, 19'd0);
        ready_i = 1'b1;
        push_base();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy_o), 1);
        wait_done("done_basic");
        chk("halt_pc", 32'(pc_o), 2);
        chk("halt_valid", 32'(valid_o), 0);
        chk("halt_busy", 32'(busy_o), 0);
        chk("sb_drained_basic", 32'(sb.size()), 0);

        // Back-pressure: outputs hold while ready_i is low
        tick();
        ready_i = 1'b0;
        push_base();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("stall_valid_seen");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(valid_o), 1);
            chk("stall_instr", {13'd0, opcode_o, operand_a_o, operand_b_o}, 32'h12314);
            chk("stall_pc", 32'(pc_o), 0);
            tick();
        end
        ready_i = 1'b1;
        wait_done("done_stall");
        chk("sb_drained_stall", 32'(sb.size()), 0);

        // Reset while in ISSUE, then rerun without reloading
        tick();
        ready_i = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("pre_reset_valid");
        do_reset();
        @(negedge clk);
        chk("abort_valid", 32'(valid_o), 0);
        chk("abort_pc", 32'(pc_o), 0);
        chk("abort_busy", 32'(busy_o), 0);
        tick();
        ready_i = 1'b1;
        push_base();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("done_after_reset");
        chk("pc_after_reset", 32'(pc_o), 2);
        chk("sb_drained_reset", 32'(sb.size()), 0);

        // Load during ISSUE must be ignored
        tick();
        ready_i = 1'b0;
        push_base();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("busy_load_valid");
        load_word(1, 19'd0);
        ready_i = 1'b1;
        wait_done("done_busy_load");
        chk("pc_busy_load", 32'(pc_o), 2);
        chk("sb_drained_busy_load", 32'(sb.size()), 0);

        // Load and start together in IDLE: write happens, start ignored
        do_reset();
        start = 1'b1;
        load_word(2, 19'b011_01010101_10101010);
        start = 1'b0;
        @(negedge clk);
        chk("ldstart_busy", 32'(busy_o), 0);
        chk("ldstart_done", 32'(done_o), 0);
        tick();
        load_word(3, 19'd0);
        push_base();
        push(3'd3, 8'h55, 8'haa, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("done_ldstart");
        chk("pc_ldstart", 32'(pc_o), 3);
        chk("sb_drained_ldstart", 32'(sb.size()), 0);

        // Full memory of DEC instructions
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] a;
            a = 8'(i);
            load_word(i, {3'd7, a, ~a});
        end
`ifdef FETCH_LOOP_EN
        for (int i = 0; i < DEPTH + 4; i++) begin
            logic [7:0] a;
            a = 8'(i % DEPTH);
            push(3'd7, a, ~a, i % DEPTH);
        end
`else
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] a;
            a = 8'(i);
            push(3'd7, a, ~a, i);
        end
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            int n = 0;
            while (sb.size() != 0 && n < 300) begin
                tick();
                n++;
            end
        end
        ready_i = 1'b0;
        chk("sb_drained_full", 32'(sb.size()), 0);
`ifdef FETCH_LOOP_EN
        @(negedge clk);
        chk("loop_not_done", 32'(done_o), 0);
        chk("loop_busy", 32'(busy_o), 1);
`else
        @(negedge clk);
        chk("full_done", 32'(done_o), 1);
        chk("full_pc", 32'(pc_o), DEPTH - 1);
`endif
        do_reset();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
